imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Writer side of the instruction-memory interface the pipelined MIPS core fetches from.
//  Receives a byte stream (valid/ready), assembles 32-bit words, writes them sequentially into
//  instruction memory from word address 0 and verifies an XOR checksum.
//  Holds the core in reset until a load completes cleanly, then releases it.
// PARAMETERS
//  ADDR_WIDTH  8  instruction-memory word-address width; capacity = 2**ADDR_WIDTH words
// PORTS
//  CLK         in   1           system clock, rising edge
//  Reset       in   1           asynchronous, active-high reset
//  start       in   1           one-cycle pulse; arms a new load (honoured only in IDLE, DONE, ERR)
//  byte_valid  in   1           byte_data is valid this cycle
//  byte_data   in   8           stream byte
//  byte_ready  out  1           loader accepts a byte this cycle
//  imem_we     out  1           instruction-memory write strobe, one cycle per word
//  imem_addr   out  ADDR_WIDTH  word address of the write
//  imem_wdata  out  32          word to write
//  core_reset  out  1           hold-reset for the core; 1 except in DONE
//  done        out  1           load finished and checksum matched
//  error       out  1           load aborted: bad length or checksum mismatch
// BEHAVIOUR
//  Reset (async): state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//   core_reset=1, done=0, error=0; length, word counter, byte index and checksum cleared.
//  Accept = byte_valid & byte_ready, sampled on the rising CLK edge.
//   byte_ready is a pure function of state: 1 in LEN_HI, LEN_LO, DATA, CHECK; 0 otherwise.
//  Stream format: LEN[15:8], LEN[7:0], then 4*LEN data bytes, then 1 checksum byte.
//  States:
//   IDLE : start -> LEN_HI; clears done, error, checksum, word counter, byte index.
//   LEN_HI: accept -> store len[15:8] -> LEN_LO.
//   LEN_LO: accept -> store len[7:0]. If len==0 or len>2**ADDR_WIDTH -> ERR, else DATA.
//   DATA : each accepted byte is XORed into the checksum.
//          Words are little-endian: byte k of a word lands in bits [8k+7:8k].
//          After the 4th byte of a word is accepted, next cycle: imem_we=1 for exactly one
//          cycle, imem_addr=word counter, imem_wdata=assembled word. Word counter then
//          increments (width ADDR_WIDTH+1, so the final word at 2**ADDR_WIDTH-1 does not wrap).
//          After the last word's 4th byte -> CHECK. byte_ready stays 1 during the write cycle.
//   CHECK: accept -> byte==checksum ? DONE : ERR. No memory write in this state.
//   DONE : core_reset=0, done=1, byte_ready=0.
//          start -> LEN_HI, with core_reset=1 and done=0 from the next cycle.
//   ERR  : error=1, core_reset=1, byte_ready=0. start -> LEN_HI, clearing error.
//  start is ignored in LEN_HI, LEN_LO, DATA and CHECK.
//  Words already written before an ERR are not rolled back.
//  Gaps in byte_valid are legal anywhere; output results are independent of stall pattern.
//  Reset mid-load: immediate return to reset values. The pending partial word is discarded
//   and never written.
//  imem_addr and imem_wdata hold their last values when imem_we=0.
// TESTING
//  T1 start; bytes 00 02 78 56 34 12 EF BE AD DE 2A
//     -> writes [0]=0x12345678, [1]=0xDEADBEEF; done=1, core_reset=0, error=0.
//  T2 as T1 but checksum byte 2B -> same two writes; error=1, done=0, core_reset=1.
//  T3 length 00 00 -> ERR after 2nd byte, no writes.
//     With ADDR_WIDTH=8, length 01 01 -> ERR; length 01 00 with valid data
//     -> writes addr 0..255, then done=1.
//  T4 T1 stream with random 0-5 cycle byte_valid gaps
//     -> identical writes; imem_we exactly 2 cycles high.
//  T5 Reset pulse after 6 stream bytes -> all outputs at reset values the same cycle,
//     no imem_we; a following start + T1 stream succeeds.
//  T6 start pulsed during DATA -> ignored. start in DONE -> core_reset=1 next cycle;
//     a new load overwrites from address 0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Purpose: loads a length-prefixed byte stream into instruction memory, verifies an XOR checksum, releases core reset.
// Latency: one memory write the cycle after the 4th byte of each word; DONE/ERR one cycle after the checksum byte.
// Backpressure: byte_ready depends only on state, high while a load is in progress and never dropped for a write.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR} state_t;

  // Largest legal length is the full memory, so the limit needs one bit more than the length field.
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                stateNext;
  logic [15:0]           lenReg;
  logic [ADDR_WIDTH:0]   wordCnt;
  logic [1:0]            byteIdx;
  logic [7:0]            checksum;
  logic [23:0]           wordBuf;
  logic                  accept;
  logic                  armed;
  logic [15:0]           lenNew;
  logic                  lenBad;
  logic                  lastWord;

  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHECK);
  assign accept     = byte_valid & byte_ready;
  assign armed      = start & ((state == IDLE) || (state == DONE) || (state == ERR));
  assign lenNew     = {lenReg[15:8], byte_data};
  assign lenBad     = (lenNew == 16'd0) || ({1'b0, lenNew} > MAX_LEN);
  // The counter is one bit wider than the address so the word at the top address does not wrap.
  assign lastWord   = (byteIdx == 2'd3) && ((17'(wordCnt) + 17'd1) == {1'b0, lenReg});

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode and status outputs.
  always_comb begin
    stateNext  = state;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE:    if (start) stateNext = LEN_HI;
      LEN_HI:  if (accept) stateNext = LEN_LO;
      LEN_LO:  if (accept) stateNext = lenBad ? ERR : DATA;
      DATA:    if (accept && lastWord) stateNext = CHECK;
      CHECK:   if (accept) stateNext = (byte_data == checksum) ? DONE : ERR;
      DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (start) stateNext = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) stateNext = LEN_HI;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Length capture, word assembly, checksum accumulation and the one-cycle memory write.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      lenReg     <= '0;
      wordCnt    <= '0;
      byteIdx    <= '0;
      checksum   <= '0;
      wordBuf    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (armed) begin
        lenReg   <= '0;
        wordCnt  <= '0;
        byteIdx  <= '0;
        checksum <= '0;
      end else if (accept) begin
        case (state)
          LEN_HI: lenReg[15:8] <= byte_data;
          LEN_LO: lenReg[7:0]  <= byte_data;
          DATA: begin
            checksum <= checksum ^ byte_data;
            byteIdx  <= byteIdx + 2'd1;
            case (byteIdx)
              2'd0: wordBuf[7:0]   <= byte_data;
              2'd1: wordBuf[15:8]  <= byte_data;
              2'd2: wordBuf[23:16] <= byte_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= wordCnt[ADDR_WIDTH-1:0];
                imem_wdata <= {byte_data, wordBuf};
                wordCnt    <= wordCnt + (ADDR_WIDTH+1)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
